// File: rtl/fix_checksum_engine.sv
// fix_checksum_engine
// FIX tag-10 checksum engine. Sums message bytes (from "8=" through the SOH
// before "10=") modulo 256, LANES bytes per beat, then emits the checksum as
// three ASCII digits (hundreds, tens, units) over a valid/ready stream.
//
// Optional feature: define CHECKSUM_VERIFY_EN to capture exp_i on the end beat
// and compare it with the computed digits (match_o / match_valid_o). Without
// it, match_o and match_valid_o are tied low and exp_i is ignored.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   data_i, keep_i  message bytes (lane 0 earliest) and per-lane enables
//   valid_i/ready_o input beat handshake; start_i/end_i frame the message
//   exp_i           expected ASCII digits {h, t, u}, sampled on the end beat
//   cs_digit_o/cs_valid_o/cs_ready_i/cs_last_o  digit stream, last = units
//   cs_bin_o        binary checksum, held until the next message converts
//   match_o/match_valid_o  comparison result and its one-cycle qualifier
//   busy_o          engine is not idle
//
// States:
//   IDLE  | waiting for a start beat; non-start beats are dropped
//   ACCUM | summing beats until the end beat; a start beat restarts
//   CONV  | one cycle: latch binary result, split into decimal digits
//   EMIT  | present h, t, u; return to IDLE on the units handshake
module fix_checksum_engine #(
  parameter int LANES = 1,
  parameter int SUM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*LANES-1:0]   data_i,
  input  logic [LANES-1:0]     keep_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 start_i,
  input  logic                 end_i,
  input  logic [23:0]          exp_i,
  output logic [7:0]           cs_digit_o,
  output logic                 cs_valid_o,
  input  logic                 cs_ready_i,
  output logic                 cs_last_o,
  output logic [7:0]           cs_bin_o,
  output logic                 match_o,
  output logic                 match_valid_o,
  output logic                 busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]       state;
  logic [SUM_W-1:0] acc;
  logic [1:0]       idx;
  logic [7:0]       dig_h, dig_t, dig_u;
  logic [7:0]       next_h, next_t, next_u;
  logic [7:0]       beat_sum;
  logic             accept;

  assign ready_o    = (state == S_IDLE) || (state == S_ACCUM);
  assign accept     = valid_i && ready_o;
  assign busy_o     = (state != S_IDLE);
  assign cs_valid_o = (state == S_EMIT);
  assign cs_last_o  = (state == S_EMIT) && (idx == 2'd2);

  // Masked lanes add zero; the carry out of bit 7 is discarded.
  always_comb begin
    beat_sum = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      if (keep_i[i]) beat_sum = beat_sum + data_i[8*i +: 8];
    end
  end

  always_comb begin
    next_h = (acc / 8'd100) + 8'h30;
    next_t = ((acc % 8'd100) / 8'd10) + 8'h30;
    next_u = (acc % 8'd10) + 8'h30;
  end

  always_comb begin
    cs_digit_o = 8'h00;
    if (state == S_EMIT) begin
      case (idx)
        2'd0:    cs_digit_o = dig_h;
        2'd1:    cs_digit_o = dig_t;
        default: cs_digit_o = dig_u;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      idx      <= 2'd0;
      cs_bin_o <= 8'h00;
      dig_h    <= 8'h00;
      dig_t    <= 8'h00;
      dig_u    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && start_i) begin
            acc   <= beat_sum;
            state <= end_i ? S_CONV : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            // A start beat abandons the message in progress.
            acc <= start_i ? beat_sum : acc + beat_sum;
            if (end_i) state <= S_CONV;
          end
        end
        S_CONV: begin
          cs_bin_o <= acc;
          dig_h    <= next_h;
          dig_t    <= next_t;
          dig_u    <= next_u;
          idx      <= 2'd0;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (cs_ready_i) begin
            if (idx == 2'd2) begin
              idx   <= 2'd0;
              acc   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CHECKSUM_VERIFY_EN
  logic [23:0] exp_reg;
  logic        match_r;
  logic        match_valid_r;
  logic        capture;

  assign capture = accept && end_i &&
                   (((state == S_IDLE) && start_i) || (state == S_ACCUM));

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_reg       <= 24'h0;
      match_r       <= 1'b0;
      match_valid_r <= 1'b0;
    end else begin
      match_valid_r <= 1'b0;
      if (capture) exp_reg <= exp_i;
      if (state == S_CONV) begin
        match_r       <= ({next_h, next_t, next_u} == exp_reg);
        match_valid_r <= 1'b1;
      end
    end
  end

  assign match_o       = match_r;
  assign match_valid_o = match_valid_r;
`else
  logic unused_exp;
  assign unused_exp    = ^exp_i;
  assign match_o       = 1'b0;
  assign match_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_fix_checksum_engine.sv
module tb_fix_checksum_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic [3:0]  keep_i;
  logic        valid_i;
  logic        ready_o;
  logic        start_i;
  logic        end_i;
  logic [23:0] exp_i;
  logic [7:0]  cs_digit_o;
  logic        cs_valid_o;
  logic        cs_ready_i;
  logic        cs_last_o;
  logic [7:0]  cs_bin_o;
  logic        match_o;
  logic        match_valid_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fix_checksum_engine #(.LANES(4), .SUM_W(8)) u_dut (
    .clk(clk), .rst(rst), .data_i(data_i), .keep_i(keep_i),
    .valid_i(valid_i), .ready_o(ready_o), .start_i(start_i), .end_i(end_i),
    .exp_i(exp_i), .cs_digit_o(cs_digit_o), .cs_valid_o(cs_valid_o),
    .cs_ready_i(cs_ready_i), .cs_last_o(cs_last_o), .cs_bin_o(cs_bin_o),
    .match_o(match_o), .match_valid_o(match_valid_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic s, input logic e, input logic [23:0] x);
    @(negedge clk);
    check("beat_ready", 32'(ready_o), 32'd1);
    data_i = d; keep_i = k; start_i = s; end_i = e; exp_i = x; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; start_i = 1'b0; end_i = 1'b0;
  endtask

  // Called at the falling edge right after the end beat was accepted (CONV).
  task automatic collect(input logic [23:0] digits, input logic [7:0] bin,
                         input logic want_match, input int hold);
    logic em, emv;
`ifdef CHECKSUM_VERIFY_EN
    em = want_match; emv = 1'b1;
`else
    em = 1'b0; emv = 1'b0;
`endif
    cs_ready_i = (hold == 0);
    check("conv_ready", 32'(ready_o), 32'd0);
    check("conv_busy", 32'(busy_o), 32'd1);
    check("conv_valid", 32'(cs_valid_o), 32'd0);
    @(negedge clk);
    check("bin", 32'(cs_bin_o), 32'(bin));
    check("match_valid", 32'(match_valid_o), 32'(emv));
    check("match", 32'(match_o), 32'(em));
    for (int j = 0; j < hold; j++) begin
      check("hold_digit", 32'(cs_digit_o), 32'(digits[23:16]));
      check("hold_valid", 32'(cs_valid_o), 32'd1);
      check("hold_ready", 32'(ready_o), 32'd0);
      @(negedge clk);
    end
    cs_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("digit", 32'(cs_digit_o), 32'(digits[23-8*k -: 8]));
      check("digit_valid", 32'(cs_valid_o), 32'd1);
      check("digit_last", 32'(cs_last_o), (k == 2) ? 32'd1 : 32'd0);
      if (k == 1) check("match_pulse_end", 32'(match_valid_o), 32'd0);
      @(negedge clk);
    end
    check("done_busy", 32'(busy_o), 32'd0);
    check("done_ready", 32'(ready_o), 32'd1);
    check("done_valid", 32'(cs_valid_o), 32'd0);
  endtask

  logic [7:0]  vb [8] = '{8'h41, 8'h41, 8'h00, 8'h63, 8'h64, 8'hC7, 8'hC8, 8'hFF};
  logic [23:0] vd [8] = '{"065", "065", "000", "099", "100", "199", "200", "255"};
  logic [23:0] vx [8] = '{"065", "066", "000", "099", "100", "199", "200", "255"};
  logic        vm [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; data_i = '0; keep_i = '0; valid_i = 1'b0; start_i = 1'b0;
    end_i = 1'b0; exp_i = '0; cs_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(cs_valid_o), 32'd0);
    check("rst_digit", 32'(cs_digit_o), 32'd0);
    check("rst_last", 32'(cs_last_o), 32'd0);
    check("rst_bin", 32'(cs_bin_o), 32'd0);
    check("rst_match", 32'(match_o), 32'd0);
    check("rst_match_valid", 32'(match_valid_o), 32'd0);

    // Single-byte messages covering the decimal boundaries.
    for (int i = 0; i < 8; i++) begin
      send_beat({24'hFFFFFF, vb[i]}, 4'b0001, 1'b1, 1'b1, vx[i]);
      collect(vd[i], vb[i], vm[i], 0);
    end

    // Wrap: 0xFF + 0x02 = 0x01.
    send_beat(32'h000000FF, 4'b0001, 1'b1, 1'b0, 24'h0);
    check("accum_busy", 32'(busy_o), 32'd1);
    send_beat(32'h00000002, 4'b0001, 1'b0, 1'b1, "001");
    collect("001", 8'h01, 1'b1, 0);

    // Multi-lane with partial keep: 0x20 + 0x10 = 0x30.
    send_beat(32'hFFFF1020, 4'b0011, 1'b1, 1'b1, "048");
    collect("048", 8'h30, 1'b1, 0);

    // All lanes: 1+2+3+4 = 10.
    send_beat(32'h01020304, 4'b1111, 1'b1, 1'b1, "010");
    collect("010", 8'h0A, 1'b1, 0);

    // Empty end beat still closes the message.
    send_beat(32'hFFFF1020, 4'b0011, 1'b1, 1'b0, 24'h0);
    send_beat(32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1, "048");
    collect("048", 8'h30, 1'b1, 0);

    // Non-start beat in IDLE is dropped.
    send_beat(32'h00000077, 4'b0001, 1'b0, 1'b1, 24'h0);
    check("drop_busy", 32'(busy_o), 32'd0);
    check("drop_valid", 32'(cs_valid_o), 32'd0);

    // Back-pressure: hold the hundreds digit for 5 cycles.
    send_beat(32'h00000041, 4'b0001, 1'b1, 1'b1, "065");
    collect("065", 8'h41, 1'b1, 5);

    // Abort: restart mid-message, 0x10 + 0x05 = 21.
    send_beat(32'h00000033, 4'b0001, 1'b1, 1'b0, 24'h0);
    send_beat(32'h00000010, 4'b0001, 1'b1, 1'b0, 24'h0);
    check("abort_no_output", 32'(cs_valid_o), 32'd0);
    send_beat(32'h00000005, 4'b0001, 1'b0, 1'b1, "021");
    collect("021", 8'h15, 1'b1, 0);

    // Reset while the tens digit is being presented.
    send_beat(32'h00000041, 4'b0001, 1'b1, 1'b1, "065");
    cs_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_digit", 32'(cs_digit_o), 32'h36);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 32'(cs_valid_o), 32'd0);
    check("rst_mid_ready", 32'(ready_o), 32'd1);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_bin", 32'(cs_bin_o), 32'd0);
    check("rst_mid_match", 32'(match_o), 32'd0);
    rst = 1'b0;

    // Engine usable again after reset.
    send_beat(32'h00000063, 4'b0001, 1'b1, 1'b1, "099");
    collect("099", 8'h63, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fix_checksum_engine.md
Name: fix_checksum_engine

Overview:
Parametrised FIX tag-10 checksum engine. Sums every message byte from the first byte of "8=" through the SOH before "10=", modulo 256, accepting LANES bytes per beat. Emits the three-digit ASCII checksum serially over a valid/ready stream. Optionally compares the result against a received checksum. Sits between the byte-lane framer and the outbound serializer / inbound validator.

Parameters:
LANES, 1, bytes per input beat (1..8); lane 0 = data_i[7:0] = earliest byte
SUM_W, 8, accumulator width; checksum = sum mod 2^SUM_W; only 8 is legal for FIX

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
data_i  in  8*LANES  message bytes
keep_i  in  LANES  per-lane byte enable; a lane with 0 contributes 0
valid_i  in  1  beat valid
ready_o  out  1  beat accepted when valid_i & ready_o
start_i  in  1  beat is the first of a message
end_i  in  1  beat is the last summed beat
exp_i  in  24  expected ASCII digits {hundreds, tens, units}; sampled on the end beat
cs_digit_o  out  8  ASCII digit, 0x30..0x39
cs_valid_o  out  1  digit valid
cs_ready_i  in  1  digit consumed when cs_valid_o & cs_ready_i
cs_last_o  out  1  units digit (third)
cs_bin_o  out  8  binary checksum; held until the next message's CONV
match_o  out  1  computed == expected
match_valid_o  out  1  one-cycle pulse qualifying match_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 except ready_o=1. State IDLE. Accumulator 0. Digit index 0.
- Beat sum = sum over lanes of (keep_i[i] ? byte_i : 0), truncated to 8 bits. The accumulator adds it mod 256 on each accepted beat.
- IDLE (ready_o=1):
  - Accepted beat with start_i: accumulator = beat sum; capture exp_i if end_i.
  - Next state: CONV if end_i, else ACCUM.
  - Accepted beat without start_i: dropped, no state change.
- ACCUM (ready_o=1):
  - Accepted beat without start_i: accumulate.
  - Accepted beat with start_i: abort the current message. Accumulator = beat sum. No output is produced for the aborted message.
  - end_i on an accepted beat: capture exp_i, go to CONV.
  - valid_i=0: hold.
- CONV (ready_o=0, one cycle):
  - cs_bin_o <= acc.
  - Digit registers: h = acc/100, t = (acc%100)/10, u = acc%10, each +0x30.
  - match_o <= ({h,t,u} == exp_reg); match_valid_o pulses in this cycle's following edge (visible 1 cycle).
  - Next state EMIT.
- EMIT (ready_o=0, cs_valid_o=1):
  - Digits are presented in order h, t, u; cs_last_o=1 on u.
  - The digit is held stable while cs_ready_i=0.
  - Index advances on handshake. Handshake on u: return to IDLE, accumulator cleared.
- Latency: end beat accepted at edge N. cs_bin_o and match valid after edge N+1. First digit cs_valid_o after edge N+1 (EMIT entered). Minimum 3 cycles in EMIT.
- Back-to-back: a new message may be accepted in the cycle after the u handshake.
- Boundaries:
  - Sum 0 -> "000". 99 -> "099". 100 -> "100". 199 -> "199". 200 -> "200". 255 -> "255".
  - Wrap: 0xFF + 0x02 -> 1.
  - All-zero keep_i on a beat: the beat still counts for start/end framing.
- rst in any state: immediate return to reset values next edge. Any partial digit stream is abandoned and cs_valid_o drops.

Optional Feature:
Macro CHECKSUM_VERIFY_EN.
- Defined: exp_i capture register, comparator, match_o and match_valid_o as above.
- Undefined: no capture or comparator logic; match_o and match_valid_o are tied 0; exp_i is ignored. All other timing is identical.

Test Plan:
- LANES=1, single beat 0x41, start=end=1, cs_ready_i=1 -> digits 0x30,0x36,0x35 ("065"); cs_bin_o=0x41; cs_last_o on third digit only.
- LANES=1, beats 0xFF then 0x02 (end) -> cs_bin_o=0x01, digits "001". Sums 100/199/200/255 -> "100"/"199"/"200"/"255".
- LANES=4, beat data 0xFFFF1020, keep 4'b0011, start=end=1 -> sum 0x30, digits "048". Then keep 4'b0000 on the end beat -> sum unchanged.
- Hold cs_ready_i=0 for 5 cycles in EMIT -> cs_digit_o=0x30 stable, ready_o=0 throughout. Release -> the remaining digits follow one per cycle, then IDLE.
- CHECKSUM_VERIFY_EN: message 0x41 with exp_i="065" -> match_o=1 with a one-cycle match_valid_o. exp_i="066" -> match_o=0. Macro undefined -> both outputs 0.
- Abort and reset: start_i mid-ACCUM with 0x10 then end beat 0x05 -> "021". Assert rst during the second digit -> cs_valid_o=0, ready_o=1, busy_o=0 next cycle.
